// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch: PC, ROM request throttling, PC-tagged show-ahead buffer, redirect flush
// Optional perf counters (perf_fetched, perf_stall) are built when IFETCH_PERF_CNT_EN is defined.
module ifetch #(
  parameter int          DWIDTH     = 16,
  parameter int          AWIDTH     = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [AWIDTH-1:0] rom_addr,
  output logic              rom_ready,
  input  logic [DWIDTH-1:0] rom_dout,
  input  logic              rom_valid,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic [DWIDTH-1:0] inst,
  output logic [AWIDTH-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [AWIDTH-1:0] r_pc;
  logic [AWIDTH-1:0] r_inflight_pc;
  logic              r_inflight;
  logic [DWIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [AWIDTH-1:0] r_fifo_pc   [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [CW-1:0]     w_occupancy;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;

  // A same-cycle pop is not credited, so an issued word always has a free slot.
  assign w_occupancy = r_count + CW'(r_inflight);
  assign w_issue     = rst_n && en && !redirect && (w_occupancy < CW'(FIFO_DEPTH));
  assign w_push      = rom_valid && r_inflight && !redirect;
  assign w_pop       = inst_valid && inst_ready && !redirect;

  assign rom_addr    = r_pc;
  assign rom_ready   = w_issue;
  assign inst_valid  = (r_count != '0);
  assign inst        = inst_valid ? r_fifo_data[r_rptr] : '0;
  assign inst_pc     = inst_valid ? r_fifo_pc[r_rptr]   : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= AWIDTH'(RESET_PC);
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue) begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + AWIDTH'(1);
      end else if (rom_valid) begin
        r_inflight <= 1'b0;
      end
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= rom_dout;
      r_fifo_pc[r_wptr]   <= r_inflight_pc;
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_push) r_perf_fetched <= r_perf_fetched + 32'd1;
      if (en && !rom_ready && !redirect) r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

  // An unsolicited response is dropped by w_push; flag it in simulation.
  assert property (@(posedge clk) disable iff (!rst_n) !(rom_valid && !r_inflight));

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed bench for ifetch with ROM model and PC scoreboard
module tb_ifetch;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] rom_addr;
  logic        rom_ready;
  logic [15:0] rom_dout;
  logic        rom_valid;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int n_iss = 0;
  int n_stall = 0;
  logic [15:0] sb[$];

  ifetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .rom_addr    (rom_addr),
    .rom_ready   (rom_ready),
    .rom_dout    (rom_dout),
    .rom_valid   (rom_valid),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_stall  (perf_stall)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM model: mem[a] = 0x1000 + a, one-cycle latency.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_valid <= 1'b0;
      rom_dout  <= 16'h0;
    end else begin
      rom_valid <= rom_ready;
      if (rom_ready) rom_dout <= 16'h1000 + rom_addr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_load(input logic [15:0] start, input int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 16'(i));
  endtask

  task automatic tick();
    logic [15:0] exp_pc;
    logic [15:0] exp_inst;
    #1;
    if (rom_ready) n_iss++;
    if (en && !rom_ready && !redirect) n_stall++;
    if (inst_valid && inst_ready && !redirect) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_pc   = sb.pop_front();
        exp_inst = 16'h1000 + exp_pc;
        chk("inst_pc", 32'(inst_pc), 32'(exp_pc));
        chk("inst", 32'(inst), 32'(exp_inst));
        n_pop++;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    inst_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_rom_ready", 32'(rom_ready), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'd0);
    chk("rst_inst_pc", 32'(inst_pc), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming from reset: first valid two cycles after the first request, no gaps.
    sb_load(16'h0, 40);
    n_pop = 0;
    en = 1'b1;
    inst_ready = 1'b1;
    #1;
    chk("lat_req", 32'(rom_ready), 32'd1);
    chk("lat_addr", 32'(rom_addr), 32'd0);
    chk("lat_c0_valid", 32'(inst_valid), 32'd0);
    tick();
    #1 chk("lat_c1_valid", 32'(inst_valid), 32'd0);
    tick();
    #1 chk("lat_c2_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("no_gap", 32'(inst_valid), 32'd1);
    end
    chk("stream_pops", 32'(n_pop), 32'd12);

    // Asynchronous reset mid-stream.
    #3 rst_n = 1'b0;
    #1;
    chk("arst_inst_valid", 32'(inst_valid), 32'd0);
    chk("arst_rom_ready", 32'(rom_ready), 32'd0);
    chk("arst_rom_addr", 32'(rom_addr), 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: buffer fills to 4, head holds pc 0, then drains in order.
    sb_load(16'h0, 40);
    n_pop = 0;
    en = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("stall_rom_ready", 32'(rom_ready), 32'd0);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_inst", 32'(inst), 32'h1000);
    chk("stall_inst_pc", 32'(inst_pc), 32'd0);
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    chk("drain_pops", 32'(n_pop), 32'd8);

    // Build 3 buffered entries plus one request in flight, then redirect.
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    #1 chk("pre_redir_issue", 32'(rom_ready), 32'd1);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    sb_load(16'h0040, 40);
    n_pop = 0;
    #1 chk("redir_no_issue", 32'(rom_ready), 32'd0);
    tick();
    redirect = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("redir_flush_valid", 32'(inst_valid), 32'd0);
    chk("redir_req", 32'(rom_ready), 32'd1);
    chk("redir_addr", 32'(rom_addr), 32'h0040);
    tick();
    #1 chk("redir_c1_valid", 32'(inst_valid), 32'd0);
    tick();
    #1 chk("redir_c2_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    chk("redir_pops", 32'(n_pop), 32'd6);

    // Redirect coinciding with a response and a pop.
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    #1;
    chk("coll_rom_valid", 32'(rom_valid), 32'd1);
    chk("coll_inst_valid", 32'(inst_valid), 32'd1);
    sb_load(16'h0080, 40);
    n_pop = 0;
    tick();
    redirect = 1'b0;
    #1;
    chk("coll_flush_valid", 32'(inst_valid), 32'd0);
    chk("coll_req", 32'(rom_ready), 32'd1);
    chk("coll_addr", 32'(rom_addr), 32'h0080);
    for (int i = 0; i < 8; i++) tick();
    chk("coll_pops", 32'(n_pop), 32'd6);

    // Back-to-back redirects (last wins) into the PC wrap.
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect_pc = 16'hFFFE;
    sb_load(16'hFFFE, 40);
    n_pop = 0;
    tick();
    redirect = 1'b0;
    #1 chk("wrap_addr", 32'(rom_addr), 32'hFFFE);
    for (int i = 0; i < 8; i++) tick();
    chk("wrap_pops", 32'(n_pop), 32'd6);

`ifdef IFETCH_PERF_CNT_EN
    // 20 fetches with a 10-cycle decode stall.
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_load(16'h0, 20);
    n_pop = 0;
    n_iss = 0;
    n_stall = 0;
    for (int c = 0; c < 60; c++) begin
      inst_ready = !(c >= 3 && c < 13);
      en = (n_iss < 20);
      tick();
    end
    #1;
    chk("perf_pops", 32'(n_pop), 32'd20);
    chk("perf_fetched", perf_fetched, 32'd20);
    chk("perf_stall", perf_stall, 32'(n_stall));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
